// File: rtl/uart_rx_sipo.sv
// UART receive deserializer: 2-flop synchronizer, mid-bit sampling FSM, valid/ack holding register.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_sipo #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 baud_clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [OSW-1:0]       os_cnt_q, os_cnt_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 commit_q, commit_d;
    logic                 stop_err_q, stop_err_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_busy_q, rx_busy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic                 par_err_s;
    logic                 rxs;

    assign rxs = sync2_q;

`ifdef UART_RX_PARITY_EN
    logic par_bit_q, par_bit_d;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    assign par_err_s = (parity_of(shreg_q, par_bit_q) != 1'(PARITY_ODD));
`else
    assign par_err_s = 1'b0;
`endif

    // Receive FSM next-state: counters, shift register and stop-bit status
    always_comb begin
        state_d    = state_q;
        os_cnt_d   = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OSW'(1);
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        commit_d   = 1'b0;
        stop_err_d = stop_err_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                os_cnt_d = '0;
                if (!rxs) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (os_cnt_q == OS_HALF) begin
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (os_cnt_q == OS_LAST) begin
                    shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (os_cnt_q == OS_LAST) begin
`ifdef UART_RX_PARITY_EN
                    par_bit_d = rxs;
`endif
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Leaving at mid stop bit keeps the next start edge in reach
                if (os_cnt_q == OS_LAST) begin
                    commit_d   = 1'b1;
                    stop_err_d = ~rxs;
                    state_d    = rxs ? ST_IDLE : ST_WAIT_HI;
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_WAIT_HI: begin
                os_cnt_d = '0;
                if (rxs) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HI;
                end
            end
            default: begin
                os_cnt_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Host holding register: commit, overrun and ack handling
    always_comb begin
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_err_d   = frame_err_q;
        parity_err_d  = parity_err_q;
        overrun_err_d = overrun_err_q;
        rx_busy_d     = (state_d != ST_IDLE);
        if (commit_q) begin
            if (!rx_valid_q || rx_ack) begin
                rx_data_d     = shreg_q;
                rx_valid_d    = 1'b1;
                frame_err_d   = stop_err_q;
                parity_err_d  = par_err_s;
                overrun_err_d = 1'b0;
            end else begin
                overrun_err_d = 1'b1;
            end
        end else if (rx_ack && rx_valid_q) begin
            rx_valid_d    = 1'b0;
            frame_err_d   = 1'b0;
            parity_err_d  = 1'b0;
            overrun_err_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // State and output registers; synchronizer presets to idle-high
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= ST_IDLE;
            os_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            commit_q      <= 1'b0;
            stop_err_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_busy_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= 1'b0;
`endif
        end else begin
            sync1_q       <= rx_in;
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            os_cnt_q      <= os_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            commit_q      <= commit_d;
            stop_err_q    <= stop_err_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_busy_q     <= rx_busy_d;
            frame_err_q   <= frame_err_d;
            parity_err_q  <= parity_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= par_bit_d;
`endif
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_busy     = rx_busy_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;
endmodule
